// File: rtl/and_gate_exerciser.sv
// Stimulus/response exerciser for a 2-input AND gate: drives a/b vectors, checks y,
// and collects per-bin coverage and a mismatch count into an on-chip pass/fail result.
module and_gate_exerciser #(
    parameter int           CNT_W    = 8,
    parameter int           HITS_REQ = 4,
    parameter int           MAX_CYC  = 255,
    parameter logic [7:0]   SEED     = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode_rand,
    output logic                 a_o,
    output logic                 b_o,
    input  logic                 y_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [4*CNT_W-1:0]   bin_hits
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t             state_r, state_next_s;
    logic               a_r, b_r, busy_r, done_r, pass_r, mode_r;
    logic [CNT_W-1:0]   err_cnt_r, chk_cnt_r;
    logic [CNT_W-1:0]   bin_r     [4];
    logic [CNT_W-1:0]   bin_inc_s [4];
    logic [CNT_W-1:0]   err_inc_s, chk_inc_s;
    logic [7:0]         lfsr_r, seed_step_s, lfsr_adv_s;
    logic [1:0]         seq_r, first_vec_s, next_vec_s;
    logic               cov_s, timeout_s;

    // Post-increment counters, exit conditions, vector selection and next state.
    always_comb begin
        state_next_s = state_r;
        cov_s        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ({a_r, b_r} == 2'(i)) begin
                bin_inc_s[i] = sat_inc(bin_r[i]);
            end else begin
                bin_inc_s[i] = bin_r[i];
            end
            cov_s = cov_s & (bin_inc_s[i] >= CNT_W'(HITS_REQ));
        end
        if (y_i != (a_r & b_r)) begin
            err_inc_s = sat_inc(err_cnt_r);
        end else begin
            err_inc_s = err_cnt_r;
        end
        chk_inc_s   = sat_inc(chk_cnt_r);
        timeout_s   = (chk_inc_s == CNT_W'(MAX_CYC));
        seed_step_s = lfsr_step(SEED);
        lfsr_adv_s  = lfsr_step(lfsr_r);
        first_vec_s = mode_rand ? seed_step_s[1:0] : 2'b00;
        next_vec_s  = mode_r ? lfsr_adv_s[1:0] : (seq_r + 2'b01);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cov_s || timeout_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: run setup on start, per-cycle check/advance in RUN, result capture on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= 1'b0;
            b_r       <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            mode_r    <= 1'b0;
            err_cnt_r <= {CNT_W{1'b0}};
            chk_cnt_r <= {CNT_W{1'b0}};
            lfsr_r    <= SEED;
            seq_r     <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                bin_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        {a_r, b_r} <= first_vec_s;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
                        mode_r     <= mode_rand;
                        err_cnt_r  <= {CNT_W{1'b0}};
                        chk_cnt_r  <= {CNT_W{1'b0}};
                        lfsr_r     <= seed_step_s;
                        seq_r      <= 2'b00;
                        for (int i = 0; i < 4; i++) begin
                            bin_r[i] <= {CNT_W{1'b0}};
                        end
                    end
                end
                RUN: begin
                    err_cnt_r <= err_inc_s;
                    chk_cnt_r <= chk_inc_s;
                    for (int i = 0; i < 4; i++) begin
                        bin_r[i] <= bin_inc_s[i];
                    end
                    if (state_next_s == DONE) begin
                        pass_r <= (err_inc_s == {CNT_W{1'b0}}) && cov_s;
                        a_r    <= 1'b0;
                        b_r    <= 1'b0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        {a_r, b_r} <= next_vec_s;
                        seq_r      <= next_vec_s;
                        if (mode_r) begin
                            lfsr_r <= lfsr_adv_s;
                        end
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign a_o     = a_r;
    assign b_o     = b_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign pass    = pass_r;
    assign err_cnt = err_cnt_r;

    for (genvar g = 0; g < 4; g++) begin : g_bins
        assign bin_hits[g*CNT_W +: CNT_W] = bin_r[g];
    end

endmodule
